// File: rtl/dfi_init_seq.sv
// -----------------------------------------------------------------------------
// dfi_init_seq
//
// Sequences the DFI initialization handshake between the memory controller and
// the PHY. A software request (init_req_i) starts a sequence: after an idle
// settle period the block raises dfi_init_start_o and waits for the PHY to
// acknowledge (dfi_init_complete_i seen low) and then complete (seen high).
// Each attempt is bounded by a timeout. A timed-out attempt is retried after
// a back-off period, up to MAX_RETRIES times, before the sequence gives up.
//
// Parameters
//   TIMEOUT_W       width of the per-attempt timeout counter
//   TIMEOUT_CYCLES  maximum cycles spent in START per attempt (1..2^TIMEOUT_W-1)
//   SETTLE_CYCLES   idle cycles before each assertion of dfi_init_start_o (>=1)
//   MAX_RETRIES     retries after the first failed attempt
//   RETRY_W         width of retry_cnt_o (must hold MAX_RETRIES)
//
// Ports
//   clk_i                in   clock
//   rst_i                in   synchronous reset, active-high
//   init_req_i           in   level request; honoured in IDLE, DONE and FAIL
//   dfi_init_complete_i  in   PHY init complete
//   dfi_init_start_o     out  init start to PHY
//   init_busy_o          out  sequence in progress (SETTLE, START, BACKOFF)
//   init_done_o          out  init completed and PHY still reports complete
//   init_fail_o          out  every attempt timed out; held until next request
//   retry_cnt_o          out  retries used in the current/last sequence
//
// All outputs are registered and change on the same edge that samples the
// inputs causing the change.
// -----------------------------------------------------------------------------
module dfi_init_seq #(
  parameter int TIMEOUT_W      = 16,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int SETTLE_CYCLES  = 4,
  parameter int MAX_RETRIES    = 2,
  parameter int RETRY_W        = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               init_req_i,
  input  logic               dfi_init_complete_i,
  output logic               dfi_init_start_o,
  output logic               init_busy_o,
  output logic               init_done_o,
  output logic               init_fail_o,
  output logic [RETRY_W-1:0] retry_cnt_o
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETTLE  = 3'd1;
  localparam logic [2:0] ST_START   = 3'd2;
  localparam logic [2:0] ST_BACKOFF = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;
  localparam logic [2:0] ST_FAIL    = 3'd5;

  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [SETTLE_W-1:0]  SETTLE_LAST  = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0]   RETRY_MAX    = RETRY_W'(MAX_RETRIES);

  logic [2:0]           state;
  logic [2:0]           state_nxt;
  logic [SETTLE_W-1:0]  settle_cnt;
  logic [TIMEOUT_W-1:0] timeout_cnt;
  logic                 ack_seen;

  logic                 settle_clr;
  logic                 retry_clr;
  logic                 retry_inc;
  logic                 start_entry;
  logic                 success;
  logic                 expiry;
  logic                 in_wait;

  // SETTLE and BACKOFF are the same idle wait; they differ only in what
  // happens to the retry count on the way in.
  assign in_wait = (state == ST_SETTLE) || (state == ST_BACKOFF);

  // A complete level only counts once the PHY has dropped it during this
  // attempt, so a level left over from a previous sequence is ignored.
  assign success = dfi_init_complete_i && ack_seen;
  assign expiry  = (timeout_cnt == TIMEOUT_LAST);

  assign start_entry = (state_nxt == ST_START) && (state != ST_START);

  // NOTE: every variable driven here gets a default first, so no branch can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    settle_clr = 1'b0;
    retry_clr  = 1'b0;
    retry_inc  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (init_req_i) begin
          state_nxt  = ST_SETTLE;
          settle_clr = 1'b1;
          retry_clr  = 1'b1;
        end
      end
      ST_SETTLE, ST_BACKOFF: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        // Success is tested first so it wins a tie with expiry.
        if (success) begin
          state_nxt = ST_DONE;
        end else if (expiry) begin
          if (retry_cnt_o < RETRY_MAX) begin
            state_nxt  = ST_BACKOFF;
            settle_clr = 1'b1;
            retry_inc  = 1'b1;
          end else begin
            state_nxt = ST_FAIL;
          end
        end
      end
      ST_DONE: begin
        // A fresh request takes priority over reporting a lost init.
        if (init_req_i) begin
          state_nxt  = ST_SETTLE;
          settle_clr = 1'b1;
          retry_clr  = 1'b1;
        end else if (!dfi_init_complete_i) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_FAIL: begin
        if (init_req_i) begin
          state_nxt  = ST_SETTLE;
          settle_clr = 1'b1;
          retry_clr  = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from the values present before the edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= ST_IDLE;
      settle_cnt       <= '0;
      timeout_cnt      <= '0;
      ack_seen         <= 1'b0;
      retry_cnt_o      <= '0;
      dfi_init_start_o <= 1'b0;
      init_busy_o      <= 1'b0;
      init_done_o      <= 1'b0;
      init_fail_o      <= 1'b0;
    end else begin
      state <= state_nxt;

      // Wait counter: cleared on entry, saturates at its terminal value.
      if (settle_clr) begin
        settle_cnt <= '0;
      end else if (in_wait && (settle_cnt < SETTLE_LAST)) begin
        settle_cnt <= settle_cnt + SETTLE_W'(1);
      end

      // Timeout counter and acknowledge flag restart with every attempt.
      if (start_entry) begin
        timeout_cnt <= '0;
        ack_seen    <= 1'b0;
      end else if (state == ST_START) begin
        if (timeout_cnt < TIMEOUT_LAST) begin
          timeout_cnt <= timeout_cnt + TIMEOUT_W'(1);
        end
        if (!dfi_init_complete_i) begin
          ack_seen <= 1'b1;
        end
      end

      // Retry count holds its last value until the next request.
      if (retry_clr) begin
        retry_cnt_o <= '0;
      end else if (retry_inc && (retry_cnt_o < RETRY_MAX)) begin
        retry_cnt_o <= retry_cnt_o + RETRY_W'(1);
      end

      // Outputs decode the next state so they change on the deciding edge.
      dfi_init_start_o <= (state_nxt == ST_START);
      init_busy_o      <= (state_nxt == ST_SETTLE) || (state_nxt == ST_START) ||
                          (state_nxt == ST_BACKOFF);
      init_done_o      <= (state_nxt == ST_DONE);
      init_fail_o      <= (state_nxt == ST_FAIL);
    end
  end

endmodule

// File: tb/tb_dfi_init_seq.sv
// -----------------------------------------------------------------------------
// tb_dfi_init_seq
//
// Two instances share one set of inputs: dut_a keeps the default timeout,
// dut_b uses an 8-cycle timeout so retry and failure paths are short. A
// behavioural model per instance predicts outputs after every clock edge.
// Inputs change on the falling edge; outputs are compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_dfi_init_seq;

  localparam int SETTLE = 4;
  localparam int MAXR   = 2;
  localparam int TMO_A  = 1000;
  localparam int TMO_B  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       cmp = 1'b0;

  logic       a_start, a_busy, a_done, a_fail;
  logic [1:0] a_retry;
  logic       b_start, b_busy, b_done, b_fail;
  logic [1:0] b_retry;

  logic [5:0] outs_a;
  logic [5:0] outs_b;
  assign outs_a = {a_start, a_busy, a_done, a_fail, a_retry};
  assign outs_b = {b_start, b_busy, b_done, b_fail, b_retry};

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dfi_init_seq dut_a (
    .clk_i               (clk),
    .rst_i               (rst),
    .init_req_i          (req),
    .dfi_init_complete_i (cmp),
    .dfi_init_start_o    (a_start),
    .init_busy_o         (a_busy),
    .init_done_o         (a_done),
    .init_fail_o         (a_fail),
    .retry_cnt_o         (a_retry)
  );

  dfi_init_seq #(.TIMEOUT_CYCLES(TMO_B)) dut_b (
    .clk_i               (clk),
    .rst_i               (rst),
    .init_req_i          (req),
    .dfi_init_complete_i (cmp),
    .dfi_init_start_o    (b_start),
    .init_busy_o         (b_busy),
    .init_done_o         (b_done),
    .init_fail_o         (b_fail),
    .retry_cnt_o         (b_retry)
  );

  // ---------------------------------------------------------------------------
  // Behavioural model: phases of the handshake, the age of the current phase
  // and the number of retries used. Settle and back-off are one "wait" phase.
  // ---------------------------------------------------------------------------
  typedef enum int {M_IDLE, M_WAIT, M_RUN, M_DONE, M_FAIL} mphase_t;
  typedef struct {
    mphase_t phase;
    int      age;
    int      retries;
    bit      ack;
  } model_t;

  model_t ma = '{M_IDLE, 0, 0, 1'b0};
  model_t mb = '{M_IDLE, 0, 0, 1'b0};

  function automatic model_t model_step(input model_t m, input bit r, input bit q,
                                        input bit c, input int tmo);
    model_t n = m;
    if (r) begin
      n = '{M_IDLE, 0, 0, 1'b0};
    end else begin
      case (m.phase)
        M_IDLE: if (q) n = '{M_WAIT, 0, 0, 1'b0};
        M_WAIT: begin
          if (m.age == SETTLE - 1) begin
            n.phase = M_RUN; n.age = 0; n.ack = 1'b0;
          end else begin
            n.age = m.age + 1;
          end
        end
        M_RUN: begin
          if (c && m.ack) begin
            n.phase = M_DONE;
          end else if (m.age == tmo - 1) begin
            if (m.retries < MAXR) begin
              n.phase = M_WAIT; n.age = 0; n.retries = m.retries + 1;
            end else begin
              n.phase = M_FAIL;
            end
          end else begin
            n.age = m.age + 1;
            if (!c) n.ack = 1'b1;
          end
        end
        M_DONE: begin
          if (q)       n = '{M_WAIT, 0, 0, 1'b0};
          else if (!c) n.phase = M_IDLE;
        end
        M_FAIL: if (q) n = '{M_WAIT, 0, 0, 1'b0};
        default: n = '{M_IDLE, 0, 0, 1'b0};
      endcase
    end
    return n;
  endfunction

  function automatic logic [5:0] model_out(input model_t m);
    return {m.phase == M_RUN, (m.phase == M_WAIT) || (m.phase == M_RUN),
            m.phase == M_DONE, m.phase == M_FAIL, 2'(m.retries)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance both models with the current inputs, let the edge
  // happen, then compare both instances on the falling edge.
  task automatic tick();
    ma = model_step(ma, rst, req, cmp, TMO_A);
    mb = model_step(mb, rst, req, cmp, TMO_B);
    @(posedge clk);
    @(negedge clk);
    check("model_a", 32'(outs_a), 32'(model_out(ma)));
    check("model_b", 32'(outs_b), 32'(model_out(mb)));
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_req();
    req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  task automatic wait_b_start(input string name);
    int n = 0;
    while (!b_start && n < 50) begin
      tick();
      n++;
    end
    check(name, 32'(b_start), 32'd1);
  endtask

  // Number of consecutive cycles dut_b's start output stays at lvl, counting
  // the cycle already observed.
  task automatic run_len_b(input logic lvl, output int n);
    n = 0;
    do begin
      n++;
      tick();
    end while ((b_start == lvl) && (n < 50));
  endtask

  typedef struct {
    bit       rst;
    bit       req;
    bit       cmp;
    bit       start;
    bit       busy;
    bit       done;
    bit       fail;
    bit [1:0] retry;
  } vec_t;

  function automatic vec_t mkv(input bit r, input bit q, input bit c, input bit s,
                               input bit b, input bit d, input bit f);
    return '{r, q, c, s, b, d, f, 2'd0};
  endfunction

  vec_t vecs[17];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    int n;
    logic [5:0] exp_v;

    // --- table: immediate responder, stale complete, loss --------------------
    vecs[0]  = mkv(1, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mkv(0, 1, 0, 0, 1, 0, 0);
    vecs[2]  = mkv(0, 0, 0, 0, 1, 0, 0);
    vecs[3]  = mkv(0, 0, 0, 0, 1, 0, 0);
    vecs[4]  = mkv(0, 0, 0, 0, 1, 0, 0);
    vecs[5]  = mkv(0, 0, 0, 1, 1, 0, 0);
    vecs[6]  = mkv(0, 0, 0, 1, 1, 0, 0);
    vecs[7]  = mkv(0, 0, 1, 0, 0, 1, 0);
    vecs[8]  = mkv(0, 1, 1, 0, 1, 0, 0);
    vecs[9]  = mkv(0, 0, 1, 0, 1, 0, 0);
    vecs[10] = mkv(0, 0, 1, 0, 1, 0, 0);
    vecs[11] = mkv(0, 0, 1, 0, 1, 0, 0);
    vecs[12] = mkv(0, 0, 1, 1, 1, 0, 0);
    vecs[13] = mkv(0, 0, 1, 1, 1, 0, 0);
    vecs[14] = mkv(0, 0, 0, 1, 1, 0, 0);
    vecs[15] = mkv(0, 0, 1, 0, 0, 1, 0);
    vecs[16] = mkv(0, 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      rst = vecs[i].rst; req = vecs[i].req; cmp = vecs[i].cmp;
      tick();
      exp_v = {vecs[i].start, vecs[i].busy, vecs[i].done, vecs[i].fail, vecs[i].retry};
      check($sformatf("vec%0d_a", i), 32'(outs_a), 32'(exp_v));
      check($sformatf("vec%0d_b", i), 32'(outs_b), 32'(exp_v));
    end

    // --- 1. nominal, default timeout --------------------------------------
    cmp = 1'b1;
    do_reset();
    tick();
    check("t1_reset_state", 32'(outs_a), 32'd0);
    pulse_req();
    n = 1;
    while (!a_start && n < 20) begin
      tick();
      n++;
    end
    check("t1_start_latency", n, 5);
    tick(); tick();
    cmp = 1'b0;
    repeat (10) tick();
    check("t1_start_held", 32'(a_start), 32'd1);
    check("t1_no_early_done", 32'(a_done), 32'd0);
    cmp = 1'b1;
    tick();
    check("t1_done", 32'(a_done), 32'd1);
    check("t1_start_low", 32'(a_start), 32'd0);
    check("t1_retry", 32'(a_retry), 32'd0);
    check("t1_fail", 32'(a_fail), 32'd0);

    // --- 2. retry then pass -----------------------------------------------
    cmp = 1'b0;
    do_reset();
    pulse_req();
    wait_b_start("t2_rise1");
    run_len_b(1'b1, n);
    check("t2_high1_len", n, 8);
    run_len_b(1'b0, n);
    check("t2_low_len", n, 4);
    check("t2_rise2", 32'(b_start), 32'd1);
    tick();
    cmp = 1'b1;
    tick();
    check("t2_done", 32'(b_done), 32'd1);
    check("t2_retry", 32'(b_retry), 32'd1);

    // --- 3. exhaustion ----------------------------------------------------
    cmp = 1'b0;
    do_reset();
    pulse_req();
    wait_b_start("t3_rise");
    for (int k = 0; k < 3; k++) begin
      run_len_b(1'b1, n);
      check($sformatf("t3_pulse%0d_len", k), n, 8);
      if (k < 2) begin
        run_len_b(1'b0, n);
        check($sformatf("t3_gap%0d_len", k), n, 4);
      end
    end
    check("t3_fail", 32'(b_fail), 32'd1);
    check("t3_retry", 32'(b_retry), 32'd2);
    check("t3_not_busy", 32'(b_busy), 32'd0);
    tick();
    check("t3_fail_sticky", 32'(b_fail), 32'd1);
    pulse_req();
    check("t3_fail_clear", 32'(b_fail), 32'd0);
    check("t3_restart_busy", 32'(b_busy), 32'd1);
    check("t3_retry_clear", 32'(b_retry), 32'd0);

    // --- 4. stale complete, then success on the expiry cycle ---------------
    cmp = 1'b1;
    do_reset();
    pulse_req();
    wait_b_start("t4_rise");
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t4_stale_nodone%0d", i), 32'(b_done), 32'd0);
    end
    cmp = 1'b0;
    tick(); tick();
    cmp = 1'b1;
    tick();
    check("t4_tie_done", 32'(b_done), 32'd1);
    check("t4_tie_retry", 32'(b_retry), 32'd0);

    // --- 5. reset during START, loss in DONE, requests while busy ----------
    cmp = 1'b0;
    do_reset();
    pulse_req();
    wait_b_start("t5_rise");
    tick();
    rst = 1'b1;
    tick();
    check("t5_rst_a", 32'(outs_a), 32'd0);
    check("t5_rst_b", 32'(outs_b), 32'd0);
    rst = 1'b0;

    pulse_req();
    wait_b_start("t5_rise2");
    tick();
    cmp = 1'b1;
    tick();
    check("t5_done", 32'(b_done), 32'd1);
    cmp = 1'b0;
    tick();
    check("t5_lost", 32'(outs_b), 32'd0);
    tick();
    check("t5_idle_stays", 32'(outs_b), 32'd0);

    pulse_req();
    n = 1;
    while (!b_start && n < 20) begin
      req = n[0];
      tick();
      n++;
    end
    req = 1'b0;
    check("t5_busy_req_latency", n, 5);
    req = 1'b1;
    run_len_b(1'b1, n);
    req = 1'b0;
    check("t5_busy_req_len", n, 8);

    // --- randomized, against the model -------------------------------------
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      req = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 5) == 0) cmp = ~cmp;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
